// File: rtl/flag_sequencer.sv
// flag_sequencer: frame-synchronous slideshow controller for the flag painters.
// Selects one of NPAT paint generators and moves between them with a fade to
// black and back, either on a button press or after HOLD_FRAMES frames. It also
// registers the brightness-scaled colour and the delayed sync/DE for the Pmod.
module flag_sequencer #(
  parameter int NPAT        = 4,
  parameter int PATW        = 2,
  parameter int HOLD_FRAMES = 300,
  parameter int HOLDW       = 9,
  parameter int FADE_STEP   = 2
) (
  input  logic            clk_pix,
  input  logic            rst_pix_n,
  input  logic            frame,
  input  logic            btn_next,
  input  logic            de_in,
  input  logic            hsync_in,
  input  logic            vsync_in,
  input  logic [4:0]      paint_r,
  input  logic [5:0]      paint_g,
  input  logic [4:0]      paint_b,
  output logic [PATW-1:0] pattern_sel,
  output logic [4:0]      level,
  output logic            busy,
  output logic            vga_de,
  output logic            vga_hsync,
  output logic            vga_vsync,
  output logic [4:0]      vga_r,
  output logic [5:0]      vga_g,
  output logic [4:0]      vga_b
);

  typedef enum logic [1:0] {SHOW, FADE_OUT, SWITCH, FADE_IN} state_t;

  localparam logic [4:0]       STEP      = 5'(FADE_STEP);
  localparam logic [4:0]       LEVEL_MAX = 5'd16;
  localparam logic [4:0]       UP_LIMIT  = LEVEL_MAX - STEP;
  localparam logic [HOLDW-1:0] HOLD_LAST = (HOLD_FRAMES == 0) ? '0 : HOLDW'(HOLD_FRAMES - 1);
  localparam logic [PATW-1:0]  SEL_LAST  = PATW'(NPAT - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_btn_q;
  logic            r_armed;
  state_t          r_state;
  logic [4:0]      r_level;
  logic [PATW-1:0] r_sel;
  logic [HOLDW-1:0] r_hold;
  logic            r_pending;
  logic            r_vga_de;
  logic            r_vga_hsync;
  logic            r_vga_vsync;
  logic [4:0]      r_vga_r;
  logic [5:0]      r_vga_g;
  logic [4:0]      r_vga_b;

  logic            w_frame;
  logic            w_press;
  logic            w_timeout;
  state_t          w_state_next;
  logic [4:0]      w_level_next;
  logic [PATW-1:0] w_sel_next;
  logic [HOLDW-1:0] w_hold_next;
  logic            w_pending_next;
  logic [9:0]      w_prod_r;
  logic [10:0]     w_prod_g;
  logic [9:0]      w_prod_b;
  logic            w_busy;

  // r_armed is low only on the first edge after reset release, so a frame
  // pulse coinciding with release is ignored everywhere.
  assign w_frame   = frame & r_armed;
  assign w_press   = w_frame & r_sync2 & ~r_btn_q;
  assign w_timeout = (HOLD_FRAMES != 0) && (r_hold == HOLD_LAST);

  // Button synchroniser plus frame-rate debounce sample, and the release arm flag.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_btn_q <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= btn_next;
      r_sync2 <= r_sync1;
      r_armed <= 1'b1;
      if (w_frame) r_btn_q <= r_sync2;
    end
  end

  // FSM state register together with the level, select, hold and pending registers.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_state   <= SHOW;
      r_level   <= LEVEL_MAX;
      r_sel     <= '0;
      r_hold    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_level   <= w_level_next;
      r_sel     <= w_sel_next;
      r_hold    <= w_hold_next;
      r_pending <= w_pending_next;
    end
  end

  // Next-state logic: everything moves only on an armed frame pulse.
  always_comb begin
    w_state_next   = r_state;
    w_level_next   = r_level;
    w_sel_next     = r_sel;
    w_hold_next    = r_hold;
    w_pending_next = r_pending;
    if (w_frame) begin
      if ((r_state != SHOW) && w_press) w_pending_next = 1'b1;
      case (r_state)
        SHOW: begin
          if (w_press || r_pending || w_timeout) begin
            w_state_next   = FADE_OUT;
            w_pending_next = 1'b0;
          end else begin
            w_hold_next = r_hold + HOLDW'(1);
          end
        end
        FADE_OUT: begin
          if (r_level <= STEP) begin
            w_level_next = '0;
            w_state_next = SWITCH;
          end else begin
            w_level_next = r_level - STEP;
          end
        end
        SWITCH: begin
          w_sel_next   = (r_sel == SEL_LAST) ? '0 : r_sel + PATW'(1);
          w_state_next = FADE_IN;
        end
        FADE_IN: begin
          if (r_level >= UP_LIMIT) begin
            w_level_next = LEVEL_MAX;
            w_hold_next  = '0;
            w_state_next = SHOW;
          end else begin
            w_level_next = r_level + STEP;
          end
        end
        default: w_state_next = SHOW;
      endcase
    end
  end

  // FSM outputs: busy whenever a change is in progress.
  always_comb begin
    w_busy = (r_state != SHOW);
  end

  assign w_prod_r = 10'(paint_r) * 10'(r_level);
  assign w_prod_g = 11'(paint_g) * 11'(r_level);
  assign w_prod_b = 10'(paint_b) * 10'(r_level);

  // Output register stage: scaled colour blanked outside DE, timing delayed to match.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_vga_de    <= 1'b0;
      r_vga_hsync <= 1'b0;
      r_vga_vsync <= 1'b0;
      r_vga_r     <= '0;
      r_vga_g     <= '0;
      r_vga_b     <= '0;
    end else begin
      r_vga_de    <= de_in;
      r_vga_hsync <= hsync_in;
      r_vga_vsync <= vsync_in;
      r_vga_r     <= de_in ? 5'(w_prod_r >> 4) : '0;
      r_vga_g     <= de_in ? 6'(w_prod_g >> 4) : '0;
      r_vga_b     <= de_in ? 5'(w_prod_b >> 4) : '0;
    end
  end

  assign pattern_sel = r_sel;
  assign level       = r_level;
  assign busy        = w_busy;
  assign vga_de      = r_vga_de;
  assign vga_hsync   = r_vga_hsync;
  assign vga_vsync   = r_vga_vsync;
  assign vga_r       = r_vga_r;
  assign vga_g       = r_vga_g;
  assign vga_b       = r_vga_b;

endmodule

// File: tb/tb_flag_sequencer.sv
// tb_flag_sequencer: randomized and directed stimulus for flag_sequencer,
// checked every cycle against a frame-level behavioural model of the slideshow.
module tb_flag_sequencer;

  localparam int NPAT        = 3;
  localparam int PATW        = 2;
  localparam int HOLD_FRAMES = 6;
  localparam int HOLDW       = 9;
  localparam int FADE_STEP   = 4;

  localparam int PH_SHOW  = 0;
  localparam int PH_OUT   = 1;
  localparam int PH_BLACK = 2;
  localparam int PH_IN    = 3;

  logic            clk_pix;
  logic            rst_pix_n;
  logic            frame;
  logic            btn_next;
  logic            de_in;
  logic            hsync_in;
  logic            vsync_in;
  logic [4:0]      paint_r;
  logic [5:0]      paint_g;
  logic [4:0]      paint_b;
  logic [PATW-1:0] pattern_sel;
  logic [4:0]      level;
  logic            busy;
  logic            vga_de;
  logic            vga_hsync;
  logic            vga_vsync;
  logic [4:0]      vga_r;
  logic [5:0]      vga_g;
  logic [4:0]      vga_b;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model state, expressed in frames and brightness units.
  int mPhase, mLevel, mSel, mHold;
  bit mPending, mSync1, mSync2, mBtnQ, mArmed;
  int eDe, eHs, eVs, eR, eG, eB;

  flag_sequencer #(
    .NPAT(NPAT), .PATW(PATW), .HOLD_FRAMES(HOLD_FRAMES),
    .HOLDW(HOLDW), .FADE_STEP(FADE_STEP)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .btn_next(btn_next),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .paint_r(paint_r), .paint_g(paint_g), .paint_b(paint_b),
    .pattern_sel(pattern_sel), .level(level), .busy(busy),
    .vga_de(vga_de), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // Safety net so the run can never hang.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = PH_SHOW; mLevel = 16; mSel = 0; mHold = 0;
    mPending = 0; mSync1 = 0; mSync2 = 0; mBtnQ = 0; mArmed = 0;
    eDe = 0; eHs = 0; eVs = 0; eR = 0; eG = 0; eB = 0;
  endtask

  // One clock edge of the reference: inputs are those present just before the edge.
  task automatic modelEdge();
    bit frameOk, press;
    frameOk = frame && mArmed;
    press   = frameOk && mSync2 && !mBtnQ;
    eDe = de_in; eHs = hsync_in; eVs = vsync_in;
    eR  = de_in ? (int'(paint_r) * mLevel) / 16 : 0;
    eG  = de_in ? (int'(paint_g) * mLevel) / 16 : 0;
    eB  = de_in ? (int'(paint_b) * mLevel) / 16 : 0;
    if (frameOk) begin
      if (mPhase == PH_SHOW) begin
        if (press || mPending || (mHold == HOLD_FRAMES - 1)) begin
          mPhase = PH_OUT;
          mPending = 0;
        end else begin
          mHold++;
        end
      end else begin
        if (press) mPending = 1;
        if (mPhase == PH_OUT) begin
          mLevel = (mLevel > FADE_STEP) ? mLevel - FADE_STEP : 0;
          if (mLevel == 0) mPhase = PH_BLACK;
        end else if (mPhase == PH_BLACK) begin
          mSel = (mSel + 1) % NPAT;
          mPhase = PH_IN;
        end else begin
          mLevel = (mLevel + FADE_STEP > 16) ? 16 : mLevel + FADE_STEP;
          if (mLevel == 16) begin
            mPhase = PH_SHOW;
            mHold = 0;
          end
        end
      end
      mBtnQ = mSync2;
    end
    mSync2 = mSync1;
    mSync1 = btn_next;
    mArmed = 1;
  endtask

  task automatic checkAll();
    checkOutput("pattern_sel", int'(pattern_sel), mSel);
    checkOutput("level", int'(level), mLevel);
    checkOutput("busy", int'(busy), int'(mPhase != PH_SHOW));
    checkOutput("vga_de", int'(vga_de), eDe);
    checkOutput("vga_hsync", int'(vga_hsync), eHs);
    checkOutput("vga_vsync", int'(vga_vsync), eVs);
    checkOutput("vga_r", int'(vga_r), eR);
    checkOutput("vga_g", int'(vga_g), eG);
    checkOutput("vga_b", int'(vga_b), eB);
  endtask

  task automatic applyStimulus();
    de_in    = 1'($urandom_range(0, 1));
    hsync_in = 1'($urandom_range(0, 1));
    vsync_in = 1'($urandom_range(0, 1));
    paint_r  = 5'($urandom_range(0, 31));
    paint_g  = 6'($urandom_range(0, 63));
    paint_b  = 5'($urandom_range(0, 31));
  endtask

  // Inputs are set around the falling edge; outputs are compared there too.
  task automatic stepCycle();
    @(posedge clk_pix);
    if (rst_pix_n) modelEdge();
    else modelReset();
    @(negedge clk_pix);
    checkAll();
  endtask

  task automatic runFrame(input int period);
    frame = 1'b1;
    applyStimulus();
    stepCycle();
    frame = 1'b0;
    for (int c = 1; c < period; c++) begin
      applyStimulus();
      stepCycle();
    end
  endtask

  initial begin
    int busyFrames;
    int guard;
    rst_pix_n = 1'b0;
    frame     = 1'b0;
    btn_next  = 1'b0;
    applyStimulus();
    modelReset();
    @(negedge clk_pix);

    // Reset held with random inputs: everything stays at reset values.
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      frame    = 1'($urandom_range(0, 1));
      btn_next = 1'($urandom_range(0, 1));
      stepCycle();
    end
    checkOutput("reset_level", int'(level), 16);
    checkOutput("reset_vga_r", int'(vga_r), 0);

    // Release with a coinciding frame pulse, which must be ignored.
    btn_next  = 1'b0;
    rst_pix_n = 1'b1;
    applyStimulus();
    frame   = 1'b1;
    paint_r = 5'd31;
    de_in   = 1'b1;
    stepCycle();
    checkOutput("release_vga_r", int'(vga_r), 31);
    checkOutput("release_busy", int'(busy), 0);
    frame = 1'b0;

    // Auto-advance: one full change within 20 frames, busy for 4+1+4 frames.
    busyFrames = 0;
    for (int f = 0; f < 20; f++) begin
      runFrame(6);
      busyFrames += int'(busy);
    end
    checkOutput("auto_busy_frames", busyFrames, 9);
    checkOutput("auto_sel", int'(pattern_sel), 1);

    // Scaling at level 8 during a fade out.
    guard = 0;
    while (!(mPhase == PH_OUT && mLevel == 8) && guard < 60) begin
      runFrame(6);
      guard++;
    end
    checkOutput("wait_level8", int'(guard < 60), 1);
    frame = 1'b0;
    applyStimulus();
    paint_r = 5'd31; paint_g = 6'd63; paint_b = 5'd1; de_in = 1'b1;
    stepCycle();
    checkOutput("scale_r", int'(vga_r), 15);
    checkOutput("scale_g", int'(vga_g), 31);
    checkOutput("scale_b", int'(vga_b), 0);
    checkOutput("scale_de", int'(vga_de), 1);
    de_in = 1'b0;
    stepCycle();
    checkOutput("blank_r", int'(vga_r), 0);
    checkOutput("blank_g", int'(vga_g), 0);
    checkOutput("blank_de", int'(vga_de), 0);

    // Wrap and pending: start freshly in SHOW on the last pattern.
    guard = 0;
    while (!(mPhase == PH_SHOW && mSel == NPAT - 1 && mHold == 0) && guard < 100) begin
      runFrame(6);
      guard++;
    end
    checkOutput("wait_last_pattern", int'(guard < 100), 1);
    for (int f = 1; f <= 32; f++) begin
      btn_next = (f inside {1, 2, 4, 5, 13, 14, 16, 17});
      runFrame(6);
      if (f == 7)  checkOutput("wrap_sel", int'(pattern_sel), 0);
      if (f == 11) checkOutput("wrap_done_level", int'(level), 16);
      if (f == 21) checkOutput("pending_sel", int'(pattern_sel), 1);
      if (f == 31) checkOutput("third_press_sel", int'(pattern_sel), 2);
      if (f == 32) checkOutput("fourth_press_lost", int'(busy), 0);
    end
    btn_next = 1'b0;

    // Debounce: five toggles between two frames, ending high, give one press.
    guard = 0;
    while (!(mPhase == PH_SHOW && mHold == 0) && guard < 100) begin
      runFrame(6);
      guard++;
    end
    checkOutput("wait_show", int'(guard < 100), 1);
    frame = 1'b1;
    applyStimulus();
    stepCycle();
    frame = 1'b0;
    for (int t = 0; t < 5; t++) begin
      btn_next = ~btn_next;
      applyStimulus();
      stepCycle();
    end
    busyFrames = 0;
    for (int f = 1; f <= 14; f++) begin
      runFrame(6);
      busyFrames += int'(busy);
    end
    checkOutput("debounce_busy_frames", busyFrames, 9);
    btn_next = 1'b0;

    // Reset asserted mid-fade at level 4.
    guard = 0;
    while (!(mPhase == PH_OUT && mLevel == 4) && guard < 100) begin
      runFrame(6);
      guard++;
    end
    checkOutput("wait_level4", int'(guard < 100), 1);
    applyStimulus();
    de_in = 1'b1; paint_r = 5'd31; paint_g = 6'd63;
    rst_pix_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset_level", int'(level), 16);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_sel", int'(pattern_sel), 0);
    checkOutput("midreset_vga_r", int'(vga_r), 0);
    checkOutput("midreset_vga_g", int'(vga_g), 0);
    checkOutput("midreset_vga_de", int'(vga_de), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      frame = 1'($urandom_range(0, 1));
      stepCycle();
    end
    @(negedge clk_pix);
    frame = 1'b0;
    rst_pix_n = 1'b1;
    applyStimulus();
    stepCycle();

    // Random frame periods and button activity.
    for (int f = 0; f < 180; f++) begin
      if ($urandom_range(0, 3) == 0) btn_next = ~btn_next;
      runFrame(int'($urandom_range(3, 8)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
